// File: rtl/kplic_claim_complete_pkg.sv
// Shared definitions for the KPLIC target-side claim/complete slice.
// Holds the default source count and field widths, plus the claim FSM state type.
package kplic_claim_complete_pkg;

  localparam int KPLIC_NUM_INT = 8;
  localparam int KPLIC_PRIO_W  = 3;
  localparam int KPLIC_ID_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP   = 2'd1,
    ST_SETTLE = 2'd2
  } claim_state_e;

endpackage

// File: rtl/kplic_prio_arb.sv
// Combinational priority arbiter for KPLIC.
// Picks the pending source with the highest non-zero priority. On a priority tie,
// the lowest ID wins. IDs are 1-based, and 0/0 means that no source is a candidate.
module kplic_prio_arb
  import kplic_claim_complete_pkg::*;
#(
  parameter int NUM_INT = KPLIC_NUM_INT,
  parameter int PRIO_W  = KPLIC_PRIO_W,
  parameter int ID_W    = KPLIC_ID_W
) (
  input  logic [NUM_INT-1:0]        pending,
  input  logic [NUM_INT*PRIO_W-1:0] int_prio,
  output logic [ID_W-1:0]           win_id,
  output logic [PRIO_W-1:0]         win_prio
);

  // Scan sources from ID 1 upward and take a source only on a strictly higher priority.
  // This keeps the lowest ID on ties, and the zero start value drops priority-0 sources.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (pending[i] && (int_prio[i*PRIO_W +: PRIO_W] > win_prio)) begin
        win_id   = ID_W'(i + 1);
        win_prio = int_prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/kplic_claim_complete.sv
// KPLIC target-side claim/complete handler.
// Collects gateway requests into pending bits and arbitrates them.
// Drives the hart's external interrupt line, serves claim reads,
// and returns completion pulses to the owning gateway.
module kplic_claim_complete
  import kplic_claim_complete_pkg::*;
#(
  parameter int NUM_INT = KPLIC_NUM_INT,
  parameter int PRIO_W  = KPLIC_PRIO_W,
  parameter int ID_W    = KPLIC_ID_W
) (
  input  logic                      kplic_clk,
  input  logic                      kplic_rstn,
  input  logic [NUM_INT-1:0]        valid_int_req,
  input  logic [NUM_INT*PRIO_W-1:0] int_prio,
  input  logic [PRIO_W-1:0]         threshold,
  input  logic                      claim_rd,
  output logic                      claim_rsp_valid,
  output logic [ID_W-1:0]           claim_id,
  output logic                      claim_busy,
  input  logic                      complete_wr,
  input  logic [ID_W-1:0]           complete_id,
  output logic [NUM_INT-1:0]        int_completion,
  output logic [NUM_INT-1:0]        int_pending,
  output logic                      ext_int_eip
);

  claim_state_e        state_q;
  claim_state_e        state_d;
  logic [NUM_INT-1:0]  pending;
  logic [NUM_INT-1:0]  in_service;
  logic [ID_W-1:0]     best_id;
  logic [PRIO_W-1:0]   best_prio;
  logic [ID_W-1:0]     arb_id;
  logic [PRIO_W-1:0]   arb_prio;
  logic                claim_fire;
  logic [NUM_INT-1:0]  claim_vec;
  logic [NUM_INT-1:0]  comp_vec;

  kplic_prio_arb #(
    .NUM_INT (NUM_INT),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_arb (
    .pending  (pending),
    .int_prio (int_prio),
    .win_id   (arb_id),
    .win_prio (arb_prio)
  );

  // Claim FSM state register.
  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Claim FSM next state. A claim read is accepted only in IDLE, and SETTLE gives the arbiter one cycle to refresh.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (claim_rd) state_d = ST_RESP;
      ST_RESP:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign claim_fire  = (state_q == ST_RESP);
  assign claim_busy  = (state_q != ST_IDLE);
  assign int_pending = pending;

  // One-hot decode of the claimed source and of a valid completion. Completion is checked against the in_service value from before this cycle.
  always_comb begin
    claim_vec = '0;
    comp_vec  = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      claim_vec[i] = claim_fire && (best_id != '0) && (best_id == ID_W'(i + 1));
      comp_vec[i]  = complete_wr && (complete_id == ID_W'(i + 1)) && in_service[i];
    end
  end

  // Pending and in-service bookkeeping. A new request beats a same-cycle claim, and a claim beats a same-cycle completion of that bit.
  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      pending    <= '0;
      in_service <= '0;
    end else begin
      pending    <= (pending & ~claim_vec) | valid_int_req;
      in_service <= (in_service & ~comp_vec) | claim_vec;
    end
  end

  // Registered arbiter result, then registered threshold compare for the hart interrupt line.
  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      best_id     <= '0;
      best_prio   <= '0;
      ext_int_eip <= 1'b0;
    end else begin
      best_id     <= arb_id;
      best_prio   <= arb_prio;
      ext_int_eip <= (best_prio > threshold);
    end
  end

  // Claim response and completion pulses. claim_id holds its value until the next response.
  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      claim_rsp_valid <= 1'b0;
      claim_id        <= '0;
      int_completion  <= '0;
    end else begin
      claim_rsp_valid <= claim_fire;
      if (claim_fire) claim_id <= best_id;
      int_completion  <= comp_vec;
    end
  end

endmodule
